// File: rtl/kernel_acc_pkg.sv
// Shared widths, FSM state and result payload for the sum_matrix row accumulator.
package kernel_acc_pkg;

   localparam int unsigned PROD_W_DEF = 62;
   localparam int unsigned ACC_W_DEF  = 64;
   localparam int unsigned CNT_W_DEF  = 16;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } kernel_state_e;

   typedef struct packed {
      logic [ACC_W_DEF-1:0] sum;
      logic [CNT_W_DEF-1:0] count;
      logic                 ovf;
   } kernel_result_t;

endpackage

// File: rtl/kernel_acc_out_reg.sv
// One-deep valid/ready holding register for a row result.
module kernel_acc_out_reg
   import kernel_acc_pkg::*;
#(
   parameter type T = kernel_result_t
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_load,
   input  T     i_data,
   input  logic i_ready,
   output logic o_valid,
   output T     o_data,
   output logic o_up_ready
);

   logic r_valid;
   T     r_data;

   // Load wins over retire so a same-cycle retire/load keeps valid high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid    = r_valid;
   assign o_data     = r_data;
   assign o_up_ready = ~r_valid | i_ready;

endmodule

// File: rtl/kernel_row_accumulate.sv
// Sums the unsigned products of one matrix row; emits sum, term count and sticky overflow.
// ACC_W must be at least PROD_W.
module kernel_row_accumulate
   import kernel_acc_pkg::*;
#(
   parameter int unsigned PROD_W = PROD_W_DEF,
   parameter int unsigned ACC_W  = ACC_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              clr,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [PROD_W-1:0] s_data,
   input  logic              s_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [ACC_W-1:0]  m_sum,
   output logic [CNT_W-1:0]  m_count,
   output logic              m_ovf
);

   localparam int unsigned SUM_W = ACC_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef struct packed {
      logic [ACC_W-1:0] sum;
      logic [CNT_W-1:0] count;
      logic             ovf;
   } row_result_t;

   kernel_state_e    r_state;
   kernel_state_e    w_state_nx;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;

   logic             w_up_ready;
   logic             w_beat;
   logic [SUM_W-1:0] w_sum_ext;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_ovf_nx;
   logic             w_emit;
   logic             w_acc_ld;
   logic             w_acc_clr;
   row_result_t      w_res_in;
   row_result_t      w_res_out;

   assign s_ready   = ~clr & w_up_ready;
   assign w_beat    = s_valid & s_ready;
   assign w_sum_ext = SUM_W'(r_acc) + SUM_W'(s_data);
   assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
   assign w_ovf_nx  = r_ovf | w_sum_ext[ACC_W];

   // State register.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) r_state <= IDLE;
      else           r_state <= w_state_nx;
   end

   // Next state: flush to IDLE, a last beat closes the row, any other beat opens/continues it.
   always_comb begin
      w_state_nx = r_state;
      if (clr)         w_state_nx = IDLE;
      else if (w_beat) w_state_nx = s_last ? IDLE : ACCUM;
   end

   // Datapath controls: a last beat emits and leaves the accumulator zeroed for the next row.
   always_comb begin
      w_emit    = 1'b0;
      w_acc_ld  = 1'b0;
      w_acc_clr = 1'b0;
      if (clr) begin
         w_acc_clr = 1'b1;
      end else if (w_beat) begin
         if (s_last) begin
            w_emit    = 1'b1;
            w_acc_clr = 1'b1;
         end else begin
            w_acc_ld  = 1'b1;
         end
      end
   end

   // Running sum, saturating term count and sticky carry for the open row.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (w_acc_clr) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (w_acc_ld) begin
         r_acc <= w_sum_ext[ACC_W-1:0];
         r_cnt <= w_cnt_inc;
         r_ovf <= w_ovf_nx;
      end
   end

   assign w_res_in.sum   = w_sum_ext[ACC_W-1:0];
   assign w_res_in.count = w_cnt_inc;
   assign w_res_in.ovf   = w_ovf_nx;

   kernel_acc_out_reg #(
      .T (row_result_t)
   ) u_out_reg (
      .clk        (ap_clk),
      .rst_n      (ap_rst_n),
      .i_load     (w_emit),
      .i_data     (w_res_in),
      .i_ready    (m_ready),
      .o_valid    (m_valid),
      .o_data     (w_res_out),
      .o_up_ready (w_up_ready)
   );

   assign m_sum   = w_res_out.sum;
   assign m_count = w_res_out.count;
   assign m_ovf   = w_res_out.ovf;

endmodule

// File: tb/tb_kernel_row_accumulate.sv
// Bench for kernel_row_accumulate: directed vector table, hand sequences, random vs. model.
module tb_kernel_row_accumulate;

   logic        clk;
   logic        rst_n;

   logic        clr, s_valid, s_ready, s_last, m_valid, m_ready, m_ovf;
   logic [61:0] s_data;
   logic [63:0] m_sum;
   logic [15:0] m_count;

   logic        b_clr, b_s_valid, b_s_ready, b_s_last, b_m_valid, b_m_ready, b_m_ovf;
   logic [61:0] b_s_data;
   logic [61:0] b_m_sum;
   logic [15:0] b_m_count;

   int n_vec = 0;
   int n_err = 0;

   kernel_row_accumulate dut (
      .ap_clk(clk), .ap_rst_n(rst_n), .clr(clr),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_sum(m_sum), .m_count(m_count), .m_ovf(m_ovf)
   );

   kernel_row_accumulate #(.PROD_W(62), .ACC_W(62), .CNT_W(16)) dut_b (
      .ap_clk(clk), .ap_rst_n(rst_n), .clr(b_clr),
      .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_last(b_s_last),
      .m_valid(b_m_valid), .m_ready(b_m_ready), .m_sum(b_m_sum), .m_count(b_m_count), .m_ovf(b_m_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        c, v;
      logic [61:0] d;
      logic        l, mr, e_rdy, e_mv;
      logic [63:0] e_sum;
      logic [15:0] e_cnt;
      logic        e_ovf;
   } vec_t;

   function automatic vec_t mk(logic c, logic v, logic [61:0] d, logic l, logic mr,
                               logic er, logic ev, logic [63:0] es, logic [15:0] ec, logic eo);
      vec_t t;
      t.c = c; t.v = v; t.d = d; t.l = l; t.mr = mr;
      t.e_rdy = er; t.e_mv = ev; t.e_sum = es; t.e_cnt = ec; t.e_ovf = eo;
      return t;
   endfunction

   typedef struct {
      logic [63:0] sum;
      logic [15:0] cnt;
      logic        ovf;
   } res_t;

   task automatic drive_a(input logic c, input logic v, input logic [61:0] d, input logic l, input logic mr);
      clr = c; s_valid = v; s_data = d; s_last = l; m_ready = mr;
   endtask

   task automatic chk_out(input string nm, input logic ev, input logic [63:0] es,
                          input logic [15:0] ec, input logic eo);
      chk({nm, ".m_valid"}, 64'(m_valid), 64'(ev));
      if (ev) begin
         chk({nm, ".m_sum"},   m_sum, es);
         chk({nm, ".m_count"}, 64'(m_count), 64'(ec));
         chk({nm, ".m_ovf"},   64'(m_ovf), 64'(eo));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   vec_t        vt[17];
   logic [61:0] maxp;
   res_t        pend[$];
   res_t        r;
   logic [127:0] tot;
   int          nterm;
   logic        exp_rdy, beat;
   logic [63:0] rnd;

   initial begin
      maxp = {62{1'b1}};
      rst_n = 1'b0;
      drive_a(1'b0, 1'b0, '0, 1'b0, 1'b1);
      b_clr = 1'b0; b_s_valid = 1'b0; b_s_data = '0; b_s_last = 1'b0; b_m_ready = 1'b1;

      #12;
      chk("reset.m_valid", 64'(m_valid), 64'd0);
      chk("reset.m_sum",   m_sum, 64'd0);
      chk("reset.m_count", 64'(m_count), 64'd0);
      chk("reset.m_ovf",   64'(m_ovf), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      //         clr   vld   data     last  mrdy  rdy   mv    sum         cnt    ovf
      vt[0]  = mk(1'b0, 1'b1, 62'd5,   1'b0, 1'b1, 1'b1, 1'b0, 64'd0,      16'd0, 1'b0);
      vt[1]  = mk(1'b0, 1'b1, 62'd7,   1'b0, 1'b1, 1'b1, 1'b0, 64'd0,      16'd0, 1'b0);
      vt[2]  = mk(1'b0, 1'b1, 62'd9,   1'b1, 1'b1, 1'b1, 1'b1, 64'd21,     16'd3, 1'b0);
      vt[3]  = mk(1'b0, 1'b0, 62'd0,   1'b0, 1'b1, 1'b1, 1'b0, 64'd0,      16'd0, 1'b0);
      vt[4]  = mk(1'b0, 1'b1, maxp,    1'b1, 1'b1, 1'b1, 1'b1, 64'(maxp),  16'd1, 1'b0);
      vt[5]  = mk(1'b0, 1'b0, 62'd0,   1'b0, 1'b0, 1'b0, 1'b1, 64'(maxp),  16'd1, 1'b0);
      vt[6]  = mk(1'b0, 1'b1, 62'd100, 1'b1, 1'b0, 1'b0, 1'b1, 64'(maxp),  16'd1, 1'b0);
      vt[7]  = mk(1'b0, 1'b1, 62'd100, 1'b1, 1'b1, 1'b1, 1'b1, 64'd100,    16'd1, 1'b0);
      vt[8]  = mk(1'b0, 1'b1, 62'd1,   1'b1, 1'b1, 1'b1, 1'b1, 64'd1,      16'd1, 1'b0);
      vt[9]  = mk(1'b0, 1'b1, 62'd2,   1'b1, 1'b1, 1'b1, 1'b1, 64'd2,      16'd1, 1'b0);
      vt[10] = mk(1'b0, 1'b1, 62'd3,   1'b1, 1'b1, 1'b1, 1'b1, 64'd3,      16'd1, 1'b0);
      vt[11] = mk(1'b0, 1'b0, 62'd0,   1'b0, 1'b1, 1'b1, 1'b0, 64'd0,      16'd0, 1'b0);
      vt[12] = mk(1'b0, 1'b1, 62'd10,  1'b0, 1'b1, 1'b1, 1'b0, 64'd0,      16'd0, 1'b0);
      vt[13] = mk(1'b0, 1'b1, 62'd20,  1'b0, 1'b1, 1'b1, 1'b0, 64'd0,      16'd0, 1'b0);
      vt[14] = mk(1'b1, 1'b1, 62'd50,  1'b1, 1'b1, 1'b0, 1'b0, 64'd0,      16'd0, 1'b0);
      vt[15] = mk(1'b0, 1'b1, 62'd3,   1'b1, 1'b1, 1'b1, 1'b1, 64'd3,      16'd1, 1'b0);
      vt[16] = mk(1'b0, 1'b0, 62'd0,   1'b0, 1'b1, 1'b1, 1'b0, 64'd0,      16'd0, 1'b0);

      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         drive_a(vt[i].c, vt[i].v, vt[i].d, vt[i].l, vt[i].mr);
         #1 chk($sformatf("vec%0d.s_ready", i), 64'(s_ready), 64'(vt[i].e_rdy));
         @(posedge clk);
         #1 chk_out($sformatf("vec%0d", i), vt[i].e_mv, vt[i].e_sum, vt[i].e_cnt, vt[i].e_ovf);
      end

      // Held result, then async reset clears outputs without a clock edge.
      @(negedge clk); drive_a(1'b0, 1'b1, 62'd10, 1'b0, 1'b1);
      @(negedge clk); drive_a(1'b0, 1'b1, 62'd5,  1'b1, 1'b0);
      @(posedge clk); #1 chk_out("held15", 1'b1, 64'd15, 16'd2, 1'b0);
      @(negedge clk); drive_a(1'b0, 1'b0, 62'd0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst.m_valid", 64'(m_valid), 64'd0);
      chk("arst.m_sum",   m_sum, 64'd0);
      chk("arst.m_count", 64'(m_count), 64'd0);
      chk("arst.m_ovf",   64'(m_ovf), 64'd0);
      @(negedge clk); rst_n = 1'b1;

      // Reset mid-row discards the partial sum.
      drive_a(1'b0, 1'b1, 62'd10, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk); drive_a(1'b0, 1'b0, 62'd0, 1'b0, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk("midrow_rst.m_valid", 64'(m_valid), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      drive_a(1'b0, 1'b1, 62'd4, 1'b1, 1'b1);
      @(posedge clk); #1 chk_out("after_rst", 1'b1, 64'd4, 16'd1, 1'b0);
      @(negedge clk); drive_a(1'b0, 1'b0, 62'd0, 1'b0, 1'b1);

      // Narrow accumulator: carry out of 62 bits sets the sticky flag, next row clean.
      @(negedge clk); b_s_valid = 1'b1; b_s_data = maxp; b_s_last = 1'b0;
      @(posedge clk); #1 chk("b.row1a.m_valid", 64'(b_m_valid), 64'd0);
      @(negedge clk); b_s_data = 62'd1; b_s_last = 1'b1;
      @(posedge clk); #1;
      chk("b.row1.m_valid", 64'(b_m_valid), 64'd1);
      chk("b.row1.m_sum",   64'(b_m_sum), 64'd0);
      chk("b.row1.m_count", 64'(b_m_count), 64'd2);
      chk("b.row1.m_ovf",   64'(b_m_ovf), 64'd1);
      @(negedge clk); b_s_data = 62'd4; b_s_last = 1'b1;
      @(posedge clk); #1;
      chk("b.row2.m_sum",   64'(b_m_sum), 64'd4);
      chk("b.row2.m_count", 64'(b_m_count), 64'd1);
      chk("b.row2.m_ovf",   64'(b_m_ovf), 64'd0);
      @(negedge clk); b_s_valid = 1'b0;

      // Random traffic against a row-level model: running exact total, pending results queue.
      do_reset();
      tot = '0; nterm = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         rnd = {$urandom(), $urandom()};
         drive_a(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 5) == 0) ? maxp : rnd[61:0],
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0));
         exp_rdy = !clr && (pend.size() == 0 || m_ready);
         beat    = s_valid && exp_rdy;
         #1 chk("rnd.s_ready", 64'(s_ready), 64'(exp_rdy));
         @(posedge clk);
         if (pend.size() != 0 && m_ready) void'(pend.pop_front());
         if (clr) begin
            tot = '0; nterm = 0;
         end else if (beat) begin
            tot   = tot + 128'(s_data);
            nterm = nterm + 1;
            if (s_last) begin
               r.sum = tot[63:0];
               r.cnt = (nterm > 65535) ? 16'hFFFF : 16'(nterm);
               r.ovf = (tot[127:64] != '0);
               pend.push_back(r);
               tot = '0; nterm = 0;
            end
         end
         #1;
         if (pend.size() != 0) chk_out("rnd", 1'b1, pend[0].sum, pend[0].cnt, pend[0].ovf);
         else                  chk_out("rnd", 1'b0, 64'd0, 16'd0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
